// File: rtl/decryption_cfg_master_if.sv
// Host request/response and register-bus signal bundle for decryption_cfg_master.
// The master modport is the view of the configuration master itself; the slave
// modport is the view of its environment (host plus register file).
interface decryption_cfg_master_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int REG_WIDTH  = 16
);
    // host request side
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [REG_WIDTH-1:0]  req_wdata;

    // host response side
    logic                  rsp_valid;
    logic [REG_WIDTH-1:0]  rsp_rdata;
    logic                  rsp_error;
    logic                  rsp_timeout;

    // register bus towards the regfile
    logic [ADDR_WIDTH-1:0] addr;
    logic                  read;
    logic                  write;
    logic [REG_WIDTH-1:0]  wdata;
    logic [REG_WIDTH-1:0]  rdata;
    logic                  done;
    logic                  error;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  rdata, done, error,
        output req_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
        output addr, read, write, wdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output rdata, done, error,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
        input  addr, read, write, wdata
    );
endinterface

// File: rtl/decryption_cfg_master.sv
// decryption_cfg_master: turns single host register requests into one register-bus
// access (one-cycle read/write strobe, then wait for done) and returns a one-cycle
// response pulse carrying read data and error status. One access in flight at a time.
// Optional feature macro: DECRYPTION_CFG_MASTER_TIMEOUT_EN -- when defined, an access
// that sees no done within TIMEOUT_CYCLES wait cycles completes with error+timeout.
// Reset rst_n is synchronous and active-low.
module decryption_cfg_master #(
    parameter int ADDR_WIDTH     = 8,
    parameter int REG_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    decryption_cfg_master_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                state_r;
    logic                  req_ready_r;
    logic                  read_r;
    logic                  write_r;
    logic                  is_write_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [REG_WIDTH-1:0]  wdata_r;
    logic                  rsp_valid_r;
    logic [REG_WIDTH-1:0]  rsp_rdata_r;
    logic                  rsp_error_r;

`ifdef DECRYPTION_CFG_MASTER_TIMEOUT_EN
    // Counter value seen in the last wait cycle that is still allowed to receive done.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0]            wait_cnt_r;
    logic                  rsp_timeout_r;
`else
    // TIMEOUT_CYCLES only matters when the timeout feature is built in.
    logic                  unused_timeout_s;
    assign unused_timeout_s = (TIMEOUT_CYCLES == 0);
`endif

    // Access sequencer: accept, strobe, wait for completion, respond; all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            req_ready_r   <= 1'b1;
            read_r        <= 1'b0;
            write_r       <= 1'b0;
            is_write_r    <= 1'b0;
            addr_r        <= {ADDR_WIDTH{1'b0}};
            wdata_r       <= {REG_WIDTH{1'b0}};
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= {REG_WIDTH{1'b0}};
            rsp_error_r   <= 1'b0;
`ifdef DECRYPTION_CFG_MASTER_TIMEOUT_EN
            wait_cnt_r    <= 8'd0;
            rsp_timeout_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        // Capture the request; write data is forced to zero for reads.
                        is_write_r  <= bus.req_write;
                        addr_r      <= bus.req_addr;
                        wdata_r     <= bus.req_write ? bus.req_wdata : {REG_WIDTH{1'b0}};
                        write_r     <= bus.req_write;
                        read_r      <= ~bus.req_write;
                        req_ready_r <= 1'b0;
                        state_r     <= ST_ISSUE;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end

                ST_ISSUE: begin
                    // Strobe lasts exactly this one cycle.
                    read_r     <= 1'b0;
                    write_r    <= 1'b0;
`ifdef DECRYPTION_CFG_MASTER_TIMEOUT_EN
                    wait_cnt_r <= 8'd0;
`endif
                    state_r    <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (bus.done) begin
                        // done has priority over an expiring timeout in the same cycle.
                        rsp_error_r   <= bus.error;
                        rsp_rdata_r   <= is_write_r ? {REG_WIDTH{1'b0}} : bus.rdata;
`ifdef DECRYPTION_CFG_MASTER_TIMEOUT_EN
                        rsp_timeout_r <= 1'b0;
`endif
                        rsp_valid_r   <= 1'b1;
                        state_r       <= ST_RESP;
                    end
`ifdef DECRYPTION_CFG_MASTER_TIMEOUT_EN
                    else if (wait_cnt_r == TIMEOUT_LAST) begin
                        rsp_error_r   <= 1'b1;
                        rsp_timeout_r <= 1'b1;
                        rsp_rdata_r   <= {REG_WIDTH{1'b0}};
                        rsp_valid_r   <= 1'b1;
                        state_r       <= ST_RESP;
                    end else begin
                        wait_cnt_r    <= wait_cnt_r + 8'd1;
                        state_r       <= ST_WAIT;
                    end
`else
                    else begin
                        state_r       <= ST_WAIT;
                    end
`endif
                end

                ST_RESP: begin
                    // One-cycle response pulse; response fields stay until the next one.
                    rsp_valid_r <= 1'b0;
                    req_ready_r <= 1'b1;
                    state_r     <= ST_IDLE;
                end

                default: begin
                    state_r     <= ST_IDLE;
                    req_ready_r <= 1'b1;
                    read_r      <= 1'b0;
                    write_r     <= 1'b0;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready   = req_ready_r;
    assign bus.read        = read_r;
    assign bus.write       = write_r;
    assign bus.addr        = addr_r;
    assign bus.wdata       = wdata_r;
    assign bus.rsp_valid   = rsp_valid_r;
    assign bus.rsp_rdata   = rsp_rdata_r;
    assign bus.rsp_error   = rsp_error_r;
`ifdef DECRYPTION_CFG_MASTER_TIMEOUT_EN
    assign bus.rsp_timeout = rsp_timeout_r;
`else
    assign bus.rsp_timeout = 1'b0;
`endif

endmodule
